// File: rtl/dmem_arbiter_if.sv
// Two requester ports plus the memory-side bus of the data-memory arbiter.
// The arbiter side uses the slave modport; requesters and the memory model use master.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              busy;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_data_out,
    output ack0, rdata0, ack1, rdata1,
    output mem_write, mem_addr, mem_data_in, busy
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_data_out,
    input  ack0, rdata0, ack1, rdata1,
    input  mem_write, mem_addr, mem_data_in, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Fixed-priority (port 0) arbiter for a single-port memory with port-1 anti-starvation.
// Grant edge -> ACCESS next cycle -> ack the cycle after; no backpressure, requesters hold req until ack.
module dmem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 3
) (
  input  logic           clock,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_gnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic [3:0]        r_starve;

  logic              w_grant;
  logic              w_gnt_id;
  logic [3:0]        w_starve_nxt;

  always_comb begin
    w_state_nxt  = r_state;
    w_grant      = 1'b0;
    w_gnt_id     = 1'b0;
    w_starve_nxt = r_starve;
    case (r_state)
      S_IDLE: begin
        if (bus.req0 && bus.req1) begin
          w_grant = 1'b1;
          // Port 1 has lost enough contested rounds; it wins this one.
          if (r_starve == LIMIT) begin
            w_gnt_id     = 1'b1;
            w_starve_nxt = 4'd0;
          end else begin
            w_gnt_id     = 1'b0;
            w_starve_nxt = r_starve + 4'd1;
          end
        end else if (bus.req0) begin
          w_grant  = 1'b1;
          w_gnt_id = 1'b0;
        end else if (bus.req1) begin
          w_grant      = 1'b1;
          w_gnt_id     = 1'b1;
          w_starve_nxt = 4'd0;
        end
        if (w_grant) begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_starve <= 4'd0;
      r_gnt    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      if (w_grant) begin
        r_gnt   <= w_gnt_id;
        r_we    <= w_gnt_id ? bus.we1    : bus.we0;
        r_addr  <= w_gnt_id ? bus.addr1  : bus.addr0;
        r_wdata <= w_gnt_id ? bus.wdata1 : bus.wdata0;
      end
      if (r_state == S_ACCESS && !r_we) begin
        if (r_gnt) begin
          r_rdata1 <= bus.mem_data_out;
        end else begin
          r_rdata0 <= bus.mem_data_out;
        end
      end
    end
  end

  // Gating with reset lets a reset during ACCESS kill the write before the edge.
  assign bus.mem_write   = (r_state == S_ACCESS) && r_we && reset;
  assign bus.mem_addr    = r_addr;
  assign bus.mem_data_in = r_wdata;
  assign bus.ack0        = (r_state == S_RESP) && !r_gnt;
  assign bus.ack1        = (r_state == S_RESP) && r_gnt;
  assign bus.rdata0      = r_rdata0;
  assign bus.rdata1      = r_rdata1;
  assign bus.busy        = (r_state != S_IDLE);

endmodule
